// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, widths and state encoding for the conv feeder
package conv_pkg;

  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int N_PIX      = IMG_W * IMG_H;
  localparam int PIX_W      = 16;
  localparam int RES_W      = 32;
  localparam int DRAIN      = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int ROW_W      = 5;
  localparam int COL_W      = 2;
  localparam int PTR_W      = 10;
  localparam int CNT_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Line-buffer select cycles 0,1,2 as image rows advance.
  function automatic logic [COL_W-1:0] col_next(input logic [COL_W-1:0] c);
    return (c == COL_W'(2)) ? '0 : c + COL_W'(1);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - generic synchronous FIFO; head reads as zero while empty
module result_fifo #(
  parameter int RES_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [RES_W-1:0] wdata,
  input  logic             pop,
  output logic [RES_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [RES_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/conv_feeder.sv
// rtl/conv_feeder.sv - buffers one image, streams it to the conv engine, collects results
module conv_feeder
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             ld_valid,
  input  logic [PIX_W-1:0] ld_data,
  output logic             ld_ready,
  output logic [PIX_W-1:0] px_data,
  output logic [ROW_W-1:0] px_row,
  output logic [COL_W-1:0] px_col,
  output logic             px_rdata,
  input  logic [RES_W-1:0] cv_data,
  input  logic             cv_wdata_fin,
  output logic             res_valid,
  output logic [RES_W-1:0] res_data,
  input  logic             res_ready,
  output logic             res_overflow,
  output logic [CNT_W-1:0] res_count
);

  state_t           state_q, state_d;
  logic             loaded_q, loaded_d;
  logic [PTR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic [PTR_W-1:0] k_q, k_d;
  logic             px_rdata_q, px_rdata_d;
  logic [ROW_W-1:0] px_row_q, px_row_d;
  logic [COL_W-1:0] px_col_q, px_col_d;
  logic             res_overflow_q, res_overflow_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;

  logic [PIX_W-1:0] img_mem [N_PIX];
  logic [PIX_W-1:0] ram_rdata;
  logic [PTR_W-1:0] rd_addr;

  logic ld_we, start_ok, in_run, cap, push, pop, fifo_full, fifo_empty;

  assign in_run   = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign ld_ready = (state_q == ST_IDLE) && !loaded_q;
  assign ld_we    = ld_valid && ld_ready;
  assign start_ok = (state_q == ST_IDLE) && start && loaded_q;
  assign cap      = cv_wdata_fin && in_run;
  assign pop      = res_ready && !fifo_empty;
  assign push     = cap && (!fifo_full || pop);

  always_comb begin
    state_d    = state_q;
    loaded_d   = loaded_q;
    ld_ptr_d   = ld_ptr_q;
    k_d        = k_q;
    px_rdata_d = px_rdata_q;
    px_row_d   = px_row_q;
    px_col_d   = px_col_q;
    rd_addr    = '0;
    case (state_q)
      ST_IDLE: begin
        if (ld_we) begin
          if (ld_ptr_q == PTR_W'(N_PIX-1)) begin
            ld_ptr_d = '0;
            loaded_d = 1'b1;
          end else begin
            ld_ptr_d = ld_ptr_q + PTR_W'(1);
          end
        end
        // rd_addr defaults to 0, so pixel 0 is ready the cycle after start.
        if (start_ok) begin
          state_d    = ST_STREAM;
          k_d        = '0;
          px_rdata_d = 1'b1;
          px_row_d   = '0;
          px_col_d   = '0;
        end
      end
      ST_STREAM: begin
        if (k_q == PTR_W'(N_PIX-1)) begin
          state_d    = ST_DRAIN;
          k_d        = '0;
          px_rdata_d = 1'b0;
        end else begin
          k_d     = k_q + PTR_W'(1);
          rd_addr = k_q + PTR_W'(1);
          if (px_row_q == ROW_W'(IMG_W-1)) begin
            px_row_d = '0;
            px_col_d = col_next(px_col_q);
          end else begin
            px_row_d = px_row_q + ROW_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (k_q == PTR_W'(DRAIN-1)) begin
          state_d = ST_DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + PTR_W'(1);
        end
      end
      default: begin
        loaded_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    res_overflow_d = res_overflow_q;
    res_count_d    = res_count_q;
    if (start_ok) begin
      res_overflow_d = 1'b0;
      res_count_d    = '0;
    end else begin
      if (push && (res_count_q != {CNT_W{1'b1}})) res_count_d = res_count_q + CNT_W'(1);
      if (cap && !push) res_overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      loaded_q       <= 1'b0;
      ld_ptr_q       <= '0;
      k_q            <= '0;
      px_rdata_q     <= 1'b0;
      px_row_q       <= '0;
      px_col_q       <= '0;
      res_overflow_q <= 1'b0;
      res_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      loaded_q       <= loaded_d;
      ld_ptr_q       <= ld_ptr_d;
      k_q            <= k_d;
      px_rdata_q     <= px_rdata_d;
      px_row_q       <= px_row_d;
      px_col_q       <= px_col_d;
      res_overflow_q <= res_overflow_d;
      res_count_q    <= res_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we) img_mem[ld_ptr_q] <= ld_data;
    ram_rdata <= img_mem[rd_addr];
  end

  result_fifo #(
    .RES_W      (RES_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (cv_data),
    .pop   (pop),
    .rdata (res_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy         = in_run;
  assign done         = (state_q == ST_DONE);
  assign px_rdata     = px_rdata_q;
  assign px_data      = px_rdata_q ? ram_rdata : '0;
  assign px_row       = px_row_q;
  assign px_col       = px_col_q;
  assign res_valid    = !fifo_empty;
  assign res_overflow = res_overflow_q;
  assign res_count    = res_count_q;

endmodule

// File: tb/tb_conv_feeder.sv
// tb/tb_conv_feeder.sv - randomized self-checking bench for conv_feeder
module tb_conv_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic [15:0] px_data;
  logic [4:0]  px_row;
  logic [1:0]  px_col;
  logic        px_rdata;
  logic [31:0] cv_data;
  logic        cv_wdata_fin;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        res_overflow;
  logic [9:0]  res_count;

  always #5 clk = ~clk;

  conv_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .px_data      (px_data),
    .px_row       (px_row),
    .px_col       (px_col),
    .px_rdata     (px_rdata),
    .cv_data      (cv_data),
    .cv_wdata_fin (cv_wdata_fin),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .res_overflow (res_overflow),
    .res_count    (res_count)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] img [784];
  logic [31:0] exp_q [$];
  int          exp_cnt;
  bit          exp_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_chk();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_px_data", px_data, 0);
    chk("rst_px_row", px_row, 0);
    chk("rst_px_col", px_col, 0);
    chk("rst_px_rdata", px_rdata, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_overflow", res_overflow, 0);
    chk("rst_res_count", res_count, 0);
  endtask

  task automatic load_img(input bit rnd, input bit early);
    int i = 0;
    int cyc = 0;
    for (int k = 0; k < 784; k++) img[k] = rnd ? 16'($urandom) : 16'(k);
    chk("ld_ready_idle", ld_ready, 1);
    ld_valid = 1'b1;
    while (i < 784 && cyc < 3000) begin
      ld_data = img[i];
      start = early && (i == 400);
      if (early && i == 401) begin
        chk("early_start_busy", busy, 0);
        chk("early_start_rdata", px_rdata, 0);
      end
      if (ld_ready) i++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ld_beats", i, 784);
    ld_data = 16'hBEEF;
    chk("ld_ready_fall", ld_ready, 0);
    repeat (3) @(negedge clk);
    chk("ld_ready_held", ld_ready, 0);
    ld_valid = 1'b0;
  endtask

  // mode 0: engine + consumer, 1: stalled consumer with 10 results,
  // 2: engine + consumer with a stray start, 3: reset at pixel 400
  task automatic run(input int mode);
    int bad_px = 0;
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    int bad_res = 0;
    int r, x;
    logic [31:0] v;
    exp_cnt = 0;
    exp_ovf = 0;
    res_ready = (mode == 0 || mode == 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_clr_count", res_count, 0);
    chk("start_clr_ovf", res_overflow, 0);
    for (int c = 0; c < 793; c++) begin
      r = c / 28;
      x = c % 28;
      if (c < 784) begin
        if (px_rdata !== 1'b1 || px_data !== img[c] || px_row !== 5'(x) || px_col !== 2'(r % 3))
          bad_px++;
      end else if (px_rdata !== 1'b0 || px_data !== 16'd0 || px_row !== 5'd27 || px_col !== 2'd0) begin
        bad_px++;
      end
      if (c == 29) begin
        chk("k29_row", px_row, 1);
        chk("k29_col", px_col, 1);
      end
      if (c == 783) begin
        chk("k783_row", px_row, 27);
        chk("k783_col", px_col, 0);
        chk("k783_rdata", px_rdata, 1);
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = c;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0 || res_data !== exp_q[0]) bad_res++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      cv_wdata_fin = 1'b0;
      start = 1'b0;
      if (mode == 3 && c == 400) begin
        rst = 1'b0;
        break;
      end
      if (c < 784 && ((mode != 1 && r >= 2 && x >= 2) || (mode == 1 && c >= 100 && c < 110))) begin
        v = $urandom;
        cv_data = v;
        cv_wdata_fin = 1'b1;
        if (exp_q.size() < 8) begin
          exp_q.push_back(v);
          if (exp_cnt < 1023) exp_cnt++;
        end else begin
          exp_ovf = 1;
        end
      end
      if (mode == 2 && c == 200) start = 1'b1;
      @(negedge clk);
    end
    chk("px_stream", bad_px, 0);
    chk("res_order", bad_res, 0);
    if (mode != 3) begin
      chk("busy_cycles", busy_n, 788);
      chk("done_pulses", done_n, 1);
      chk("done_cycle", done_at, 788);
    end
  endtask

  task automatic drain_chk();
    int bad = 0;
    res_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (res_valid) begin
        if (exp_q.size() == 0 || res_data !== exp_q[0]) bad++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    chk("drain_order", bad, 0);
    chk("drain_left", exp_q.size(), 0);
    chk("drain_valid", res_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    ld_valid = 1'b0;
    ld_data = '0;
    cv_data = '0;
    cv_wdata_fin = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_chk();
    rst = 1'b1;
    @(negedge clk);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_unloaded_busy", busy, 0);

    load_img(1'b0, 1'b1);
    run(0);
    drain_chk();
    chk("run0_count", res_count, exp_cnt);
    chk("run0_count_676", res_count, 676);
    chk("run0_ovf", res_overflow, exp_ovf);

    load_img(1'b1, 1'b0);
    run(1);
    chk("run1_count", res_count, 8);
    chk("run1_ovf", res_overflow, 1);
    chk("run1_valid", res_valid, 1);
    drain_chk();
    chk("run1_ovf_sticky", res_overflow, exp_ovf);

    load_img(1'b1, 1'b0);
    run(2);
    drain_chk();
    chk("run2_count", res_count, exp_cnt);
    chk("run2_ovf", res_overflow, 0);

    load_img(1'b1, 1'b0);
    run(3);
    #1;
    reset_chk();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ld_ready", ld_ready, 1);
    chk("post_rst_busy", busy, 0);

    load_img(1'b1, 1'b0);
    run(0);
    drain_chk();
    chk("run4_count", res_count, exp_cnt);
    chk("run4_ovf", res_overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
